// File: rtl/scan_chain_integrity_checker.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_integrity_checker
// Description : On-chip scan-chain integrity tester. Drives NUM_CHAINS scan
//               chains in parallel with a selectable pattern, fills each chain
//               for CHAIN_LEN cycles, then compares the scan-out of every chain
//               against the pattern for a further CHAIN_LEN cycles. Reports a
//               per-chain sticky fail mask, a saturating mismatch count and a
//               pass flag qualified by a one-cycle done pulse.
//
// Ports       : refclk    - single clock, all state on rising edge
//               reset     - synchronous, active-high
//               start     - begin a run (honoured only when idle)
//               pattern   - 00 zeros, 01 ones, 10 alternating, 11 0011 repeating
//               se        - scan enable to the chains (registered)
//               si        - scan-in, same bit to every chain (registered)
//               so        - scan-out from each chain
//               busy      - run in progress (fill, check, report)
//               done      - one-cycle end-of-run pulse
//               pass      - 1 when the run saw no mismatches; held until next start
//               fail_mask - sticky per-chain mismatch flags for the current run
//               err_cnt   - total mismatching (chain,cycle) samples, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_integrity_checker #(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 10,
    parameter int CNT_W      = 8
) (
    input  logic                  refclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            pattern,
    output logic                  se,
    output logic [NUM_CHAINS-1:0] si,
    input  logic [NUM_CHAINS-1:0] so,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_CHAINS-1:0] fail_mask,
    output logic [CNT_W-1:0]      err_cnt
);

    // The shift counter is sized from the chain length alone so that a narrow
    // error counter (small CNT_W) never limits the run length.
    localparam int c_K_W   = $clog2(2 * CHAIN_LEN + 1);
    localparam int c_PC_W  = $clog2(NUM_CHAINS + 1);
    localparam int c_SUM_W = ((CNT_W > c_PC_W) ? CNT_W : c_PC_W) + 1;

    localparam logic [c_K_W-1:0]   c_LEN        = c_K_W'(CHAIN_LEN);
    localparam logic [c_K_W-1:0]   c_LAST_FILL  = c_K_W'(CHAIN_LEN - 1);
    localparam logic [c_K_W-1:0]   c_LAST_CHECK = c_K_W'(2 * CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]   c_ERR_MAX    = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FILL   = 2'd1;
    localparam logic [1:0] c_ST_CHECK  = 2'd2;
    localparam logic [1:0] c_ST_REPORT = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_pat;
    logic [c_K_W-1:0]      r_k;
    logic                  r_se;
    logic [NUM_CHAINS-1:0] r_si;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [NUM_CHAINS-1:0] r_fail_mask;
    logic [CNT_W-1:0]      r_err_cnt;

    logic [c_K_W-1:0]      w_k_next;
    logic [c_K_W-1:0]      w_k_chk;
    logic                  w_exp;
    logic [NUM_CHAINS-1:0] w_mism;
    logic [c_PC_W-1:0]     w_popcnt;
    logic [c_SUM_W-1:0]    w_sum;
    logic [CNT_W-1:0]      w_err_next;
    logic [NUM_CHAINS-1:0] w_mask_next;

    // Pattern bit for shift index k.
    function automatic logic f_pbit(input logic [1:0] pat, input logic [c_K_W-1:0] k);
        logic b;
        case (pat)
            2'b00:   b = 1'b0;
            2'b01:   b = 1'b1;
            2'b10:   b = k[0];
            default: b = k[1];
        endcase
        return b;
    endfunction

    assign w_k_next = r_k + 1'b1;
    // The bit now leaving each chain was driven CHAIN_LEN shifts ago.
    assign w_k_chk  = r_k - c_LEN;
    assign w_exp    = f_pbit(r_pat, w_k_chk);

    // Case inequality so that an unknown scan-out is reported as a mismatch.
    generate
        for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_cmp
            assign w_mism[c] = (r_state == c_ST_CHECK) && (so[c] !== w_exp);
        end
    endgenerate

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            w_popcnt = w_popcnt + c_PC_W'(w_mism[i]);
        end
    end

    assign w_sum       = c_SUM_W'(r_err_cnt) + c_SUM_W'(w_popcnt);
    assign w_err_next  = (w_sum > c_SUM_W'(c_ERR_MAX)) ? c_ERR_MAX : w_sum[CNT_W-1:0];
    assign w_mask_next = r_fail_mask | w_mism;

    always_ff @(posedge refclk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pat       <= 2'b00;
            r_k         <= '0;
            r_se        <= 1'b0;
            r_si        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_se   <= 1'b0;
                    r_si   <= '0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_pat       <= pattern;
                        r_fail_mask <= '0;
                        r_err_cnt   <= '0;
                        r_pass      <= 1'b0;
                        r_k         <= '0;
                        r_busy      <= 1'b1;
                        r_se        <= 1'b1;
                        r_si        <= {NUM_CHAINS{f_pbit(pattern, '0)}};
                        r_state     <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    r_k  <= w_k_next;
                    r_si <= {NUM_CHAINS{f_pbit(r_pat, w_k_next)}};
                    if (r_k == c_LAST_FILL) begin
                        r_state <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    r_k         <= w_k_next;
                    r_fail_mask <= w_mask_next;
                    r_err_cnt   <= w_err_next;
                    if (r_k == c_LAST_CHECK) begin
                        // pass must already include this final compare.
                        r_se    <= 1'b0;
                        r_si    <= '0;
                        r_done  <= 1'b1;
                        r_pass  <= ~|w_mask_next;
                        r_state <= c_ST_REPORT;
                    end else begin
                        r_si <= {NUM_CHAINS{f_pbit(r_pat, w_k_next)}};
                    end
                end
                c_ST_REPORT: begin
                    // start is deliberately not sampled here.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_se    <= 1'b0;
                    r_si    <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign se        = r_se;
    assign si        = r_si;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_integrity_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_chain_integrity_checker
// Description : Self-checking bench. Two checkers share clock, reset, start
//               and pattern: one with an 8-bit error counter driving modelled
//               chains with configurable faults, one with a 3-bit error counter
//               whose chains are both stuck-at-0 at the scan-out. Results are
//               predicted from the pattern definition and the fault description.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_integrity_checker;

    localparam int c_L = 10;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic [1:0] pattern = 2'b00;

    logic       se_a, busy_a, done_a, pass_a;
    logic [1:0] si_a, so_a, fm_a;
    logic [7:0] ec_a;

    logic       se_b, busy_b, done_b, pass_b;
    logic [1:0] si_b, so_b, fm_b;
    logic [2:0] ec_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Fault description of the chains attached to checker A.
    int         len_a   [2];
    bit         sten_a  [2];
    int         stidx_a [2];
    bit         stv_a   [2];
    // Checker B: both chains stuck-at-0.
    int         len_b   [2];
    bit         sten_b  [2];
    bit         stv_b   [2];

    logic [c_L-1:0] ch_a [2];
    logic [c_L-1:0] ch_tmp;

    always #5 refclk = ~refclk;

    scan_chain_integrity_checker #(.NUM_CHAINS(2), .CHAIN_LEN(c_L), .CNT_W(8)) u_dut_a (
        .refclk(refclk), .reset(reset), .start(start), .pattern(pattern),
        .se(se_a), .si(si_a), .so(so_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_mask(fm_a), .err_cnt(ec_a)
    );

    scan_chain_integrity_checker #(.NUM_CHAINS(2), .CHAIN_LEN(c_L), .CNT_W(3)) u_dut_b (
        .refclk(refclk), .reset(reset), .start(start), .pattern(pattern),
        .se(se_b), .si(si_b), .so(so_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_mask(fm_b), .err_cnt(ec_b)
    );

    // Chain model for A: shift register of c_L flops; scan-out taken from
    // flop len-1; a stuck flop forces its value whenever it is loaded.
    always @(posedge refclk) begin
        if (se_a) begin
            for (int c = 0; c < 2; c++) begin
                ch_tmp = {ch_a[c][c_L-2:0], si_a[c]};
                if (sten_a[c]) ch_tmp[stidx_a[c]] = stv_a[c];
                ch_a[c] <= ch_tmp;
            end
        end
    end

    always_comb begin
        so_a = 2'b00;
        for (int c = 0; c < 2; c++) so_a[c] = ch_a[c][len_a[c]-1];
    end

    assign so_b = 2'b00;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pbit(input logic [1:0] pat, input int k);
        case (pat)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return bit'(k % 2);
            default: return bit'((k / 2) % 2);
        endcase
    endfunction

    // Compare window covers shifts c_L..2*c_L-1; chain c of length len
    // presents at shift t the bit driven at t-len, or its stuck value.
    function automatic void ref_model(input logic [1:0] pat, input int lens[2],
                                      input bit sten[2], input bit stv[2], input int maxc,
                                      output logic [1:0] mask, output int errs);
        mask = 2'b00;
        errs = 0;
        for (int t = c_L; t < 2 * c_L; t++) begin
            for (int c = 0; c < 2; c++) begin
                bit want, obs;
                want = pbit(pat, t - c_L);
                obs  = sten[c] ? stv[c] : pbit(pat, t - lens[c]);
                if (obs != want) begin
                    mask[c] = 1'b1;
                    errs++;
                end
            end
        end
        if (errs > maxc) errs = maxc;
    endfunction

    task automatic set_fault_free();
        for (int c = 0; c < 2; c++) begin
            len_a[c] = c_L; sten_a[c] = 1'b0; stidx_a[c] = 0; stv_a[c] = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_se"},   32'(se_a),   32'd0);
        check_eq({tag, "_si"},   32'(si_a),   32'd0);
        check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
        check_eq({tag, "_done"}, 32'(done_a), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass_a), 32'd0);
        check_eq({tag, "_mask"}, 32'(fm_a),   32'd0);
        check_eq({tag, "_err"},  32'(ec_a),   32'd0);
        check_eq({tag, "_busyb"},32'(busy_b), 32'd0);
        check_eq({tag, "_errb"}, 32'(ec_b),   32'd0);
    endtask

    // One run. glitch_cyc: cycle in which start is pulsed while busy (0 = none).
    // abort_cyc: cycle in which reset is asserted (0 = none).
    task automatic run_test(input string name, input logic [1:0] pat, input int glitch_cyc,
                            input bit start_in_done, input int abort_cyc, input bit scramble);
        logic [1:0] em_a, em_b;
        int         ee_a, ee_b, seen;
        ref_model(pat, len_a, sten_a, stv_a, 255, em_a, ee_a);
        ref_model(pat, len_b, sten_b, stv_b, 7, em_b, ee_b);
        @(negedge refclk);
        pattern = pat;
        start   = 1'b1;
        @(negedge refclk);
        start = 1'b0;
        for (int n = 1; n <= 2 * c_L + 1; n++) begin
            check_eq({name, "_busy"}, 32'(busy_a), 32'd1);
            check_eq({name, "_se"},   32'(se_a),   32'(n <= 2 * c_L));
            check_eq({name, "_done"}, 32'(done_a), 32'(n == 2 * c_L + 1));
            check_eq({name, "_doneb"},32'(done_b), 32'(n == 2 * c_L + 1));
            if (n <= 2 * c_L)
                check_eq({name, "_si"}, 32'(si_a), 32'({2{pbit(pat, n - 1)}}));
            if (n == abort_cyc) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge refclk);
                reset = 1'b0;
                check_idle_outputs({name, "_abort"});
                seen = 0;
                for (int m = 0; m < 2 * c_L + 5; m++) begin
                    @(negedge refclk);
                    if (done_a || done_b || busy_a) seen++;
                end
                check_eq({name, "_nodone"}, 32'(seen), 32'd0);
                return;
            end
            if (scramble) pattern = 2'($urandom);
            start = (n == glitch_cyc);
            if (n == 2 * c_L + 1) begin
                check_eq({name, "_pass"},  32'(pass_a), 32'(em_a == 2'b00));
                check_eq({name, "_mask"},  32'(fm_a),   32'(em_a));
                check_eq({name, "_err"},   32'(ec_a),   32'(ee_a));
                check_eq({name, "_passb"}, 32'(pass_b), 32'(em_b == 2'b00));
                check_eq({name, "_maskb"}, 32'(fm_b),   32'(em_b));
                check_eq({name, "_errb"},  32'(ec_b),   32'(ee_b));
                if (start_in_done) start = 1'b1;
            end
            @(negedge refclk);
        end
        start = 1'b0;
        check_eq({name, "_idle_busy"}, 32'(busy_a), 32'd0);
        check_eq({name, "_idle_done"}, 32'(done_a), 32'd0);
        check_eq({name, "_idle_se"},   32'(se_a),   32'd0);
        repeat (3) @(negedge refclk);
        check_eq({name, "_hold_busy"}, 32'(busy_a), 32'd0);
        check_eq({name, "_hold_mask"}, 32'(fm_a),   32'(em_a));
        check_eq({name, "_hold_err"},  32'(ec_a),   32'(ee_a));
        check_eq({name, "_hold_pass"}, 32'(pass_a), 32'(em_a == 2'b00));
    endtask

    initial begin
        int kind;
        set_fault_free();
        for (int c = 0; c < 2; c++) begin
            len_b[c] = c_L; sten_b[c] = 1'b1; stv_b[c] = 1'b0;
        end

        repeat (2) @(negedge refclk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge refclk);

        run_test("all0_clean", 2'b00, 0, 1'b0, 0, 1'b0);

        set_fault_free();
        sten_a[1] = 1'b1; stidx_a[1] = 4; stv_a[1] = 1'b0;
        run_test("all1_sa0", 2'b01, 0, 1'b0, 0, 1'b0);

        set_fault_free();
        len_a[0] = c_L - 1;
        run_test("alt_short", 2'b10, 0, 1'b0, 0, 1'b0);

        set_fault_free();
        run_test("p0011_glitch", 2'b11, 5, 1'b0, 0, 1'b1);

        run_test("abort", 2'b01, 0, 1'b0, 12, 1'b0);
        run_test("after_abort", 2'b00, 0, 1'b1, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            set_fault_free();
            for (int c = 0; c < 2; c++) begin
                kind = int'($urandom_range(0, 3));
                if (kind >= 2) len_a[c] = c_L - int'($urandom_range(1, 2));
                if (kind == 1 || kind == 3) begin
                    sten_a[c]  = 1'b1;
                    stidx_a[c] = int'($urandom_range(0, len_a[c] - 1));
                    stv_a[c]   = bit'($urandom_range(0, 1));
                end
            end
            run_test("rand", 2'($urandom), ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 2 * c_L)) : 0,
                     bit'($urandom_range(0, 1)), 0, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge refclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
